// File: rtl/bch_encode_pkg.sv
// Shared BCH helpers: FSM state type, GF(2^M) arithmetic and generator-polynomial construction.
// The decoder chain reuses bch_gen/bch_degree so both ends agree on g(x).
package bch_encode_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

    localparam int MAX_M   = 8;
    localparam int MAX_N   = (1 << MAX_M) - 1;
    localparam int MAX_DEG = 64;

    function automatic int bch_prim(input int m);
        case (m)
            3:       return 'h0B;
            4:       return 'h13;
            5:       return 'h25;
            6:       return 'h43;
            7:       return 'h89;
            default: return 'h11D;
        endcase
    endfunction

    function automatic int gf_mul(input int a, input int b, input int m);
        int r, x, y;
        r = 0;
        x = a;
        y = b;
        for (int i = 0; i < m; i++) begin
            if ((y & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & (1 << m)) != 0) x = x ^ bch_prim(m);
            y = y >> 1;
        end
        return r;
    endfunction

    // g(x) = product of (x + a^j) over the cyclotomic cosets of a^1..a^2T; coefficients end up in {0,1}
    function automatic logic [MAX_DEG:0] bch_gen(input int m, input int t);
        int               n, a, deg, j, c;
        int               alpha [0:MAX_N-1];
        int               g     [0:MAX_DEG];
        bit               done  [0:MAX_N-1];
        logic [MAX_DEG:0] res;
        n = (1 << m) - 1;
        a = 1;
        for (int i = 0; i < MAX_N; i++) begin
            alpha[i] = a;
            done[i]  = 1'b0;
            if (i < n) begin
                a = a << 1;
                if ((a & (1 << m)) != 0) a = a ^ bch_prim(m);
            end
        end
        for (int k = 0; k <= MAX_DEG; k++) g[k] = 0;
        g[0] = 1;
        deg  = 0;
        for (int i = 1; i <= 2 * t; i++) begin
            c = i % n;
            if (!done[c]) begin
                j = c;
                do begin
                    done[j] = 1'b1;
                    if (deg < MAX_DEG) begin
                        for (int k = deg + 1; k >= 1; k--)
                            g[k] = g[k-1] ^ gf_mul(g[k], alpha[j], m);
                        g[0] = gf_mul(g[0], alpha[j], m);
                        deg  = deg + 1;
                    end
                    j = (2 * j) % n;
                end while (j != c);
            end
        end
        res = '0;
        for (int k = 0; k <= MAX_DEG; k++) res[k] = (g[k] != 0);
        return res;
    endfunction

    function automatic int bch_degree(input logic [MAX_DEG:0] g);
        int d;
        d = 0;
        for (int k = 0; k <= MAX_DEG; k++) if (g[k]) d = k;
        return d;
    endfunction

endpackage

// File: rtl/bch_encode_lfsr.sv
// Galois LFSR dividing the serial message by g(x); the register holds the running remainder.
module bch_encode_lfsr
    import bch_encode_pkg::*;
#(
    parameter int                  ECC_BITS = 8,
    parameter logic [ECC_BITS-1:0] GEN      = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic clear,
    input  logic feed,
    input  logic in,
    output logic msb
);

    logic [ECC_BITS-1:0] r_lfsr;
    logic [ECC_BITS-1:0] w_base;
    logic                w_fb;

    // A restarting frame divides from a zero remainder, so the old parity never leaks in
    assign w_base = clear ? '0 : r_lfsr;
    assign w_fb   = feed & (in ^ w_base[ECC_BITS-1]);
    assign msb    = r_lfsr[ECC_BITS-1];

    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= '0;
        else if (ce)
            r_lfsr <= {w_base[ECC_BITS-2:0], 1'b0} ^ (w_fb ? GEN : '0);
    end

endmodule

// File: rtl/bch_encode.sv
// Systematic serial BCH encoder: message bits pass through, then the ECC_BITS remainder follows MSB first.
module bch_encode
    import bch_encode_pkg::*;
#(
    parameter int M         = 4,
    parameter int T         = 2,
    parameter int DATA_BITS = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic start,
    input  logic data_in,
    output logic ready,
    output logic data_out,
    output logic first,
    output logic last,
    output logic busy
);

    localparam logic [MAX_DEG:0]   GEN_FULL = bch_gen(M, T);
    localparam int                 ECC_BITS = bch_degree(GEN_FULL);
    localparam int                 N        = (1 << M) - 1;
    localparam int                 CNT_W    = $clog2(((DATA_BITS > ECC_BITS) ? DATA_BITS : ECC_BITS) + 1);
    localparam logic [ECC_BITS-1:0] GEN     = GEN_FULL[ECC_BITS-1:0];

    if (M < 3 || M > MAX_M) begin : g_bad_m
        $error("bch_encode: M out of supported range");
    end
    if (DATA_BITS < 1 || DATA_BITS > N - ECC_BITS) begin : g_bad_k
        $error("bch_encode: DATA_BITS exceeds N-ECC_BITS");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_data_out, r_first, r_last;
    logic             w_accept, w_feed, w_lfsr_ce, w_msb;

    // The cycle presenting the final parity bit is already IDLE, so start there chains frames with no bubble
    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE) | r_last;
    assign w_accept  = ce & start & ready;
    assign w_feed    = w_accept | (r_state == S_DATA);
    assign w_lfsr_ce = ce & (w_accept | (r_state != S_IDLE));

    assign data_out = r_data_out;
    assign first    = r_first;
    assign last     = r_last;

    bch_encode_lfsr #(.ECC_BITS(ECC_BITS), .GEN(GEN)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .ce    (w_lfsr_ce),
        .clear (w_accept),
        .feed  (w_feed),
        .in    (data_in),
        .msb   (w_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_data_out <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
        end else if (ce) begin
            if (w_accept) begin
                r_state    <= (DATA_BITS == 1) ? S_PARITY : S_DATA;
                r_count    <= (DATA_BITS == 1) ? '0 : CNT_W'(1);
                r_data_out <= data_in;
                r_first    <= 1'b1;
                r_last     <= 1'b0;
            end else begin
                r_data_out <= 1'b0;
                r_first    <= 1'b0;
                r_last     <= 1'b0;
                case (r_state)
                    S_DATA: begin
                        r_data_out <= data_in;
                        if (r_count == CNT_W'(DATA_BITS - 1)) begin
                            r_state <= S_PARITY;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_data_out <= w_msb;
                        if (r_count == CNT_W'(ECC_BITS - 1)) begin
                            r_last  <= 1'b1;
                            r_state <= S_IDLE;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
